// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants (active-low, bit order {g,f,e,d,c,b,a})
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_I     = 7'b1111001;
endpackage

// File: rtl/refresh_tick.sv
// refresh_tick: digit refresh divider, pulses tick on the wrap cycle while enabled
module refresh_tick #(
  parameter int REFRESH_DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  logic [15:0] rc;
  assign tick = en && (rc == 16'(REFRESH_DIV - 1));
  // count 0..REFRESH_DIV-1 while enabled, hold otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) rc <= '0;
    else if (en) rc <= tick ? '0 : rc + 16'd1;
endmodule

// File: rtl/seg_scroll_mux.sv
// seg_scroll_mux: scrolling 4-digit seven-segment display multiplexer
module seg_scroll_mux #(
  parameter int REFRESH_DIV = 5000,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [6:0]            seg_in,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);
  import seg_pkg::*;
  logic                       tick, frame, pend;
  logic [1:0]                 sidx;
  logic [6:0]                 hold;
  logic [NUM_DIGITS-1:0][6:0] d;
  assign seg_ready = !pend;
  assign frame = tick && (sidx == 2'd3);
  refresh_tick #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );
  // scan index advances once per refresh tick
  always_ff @(posedge clk or posedge rst)
    if (rst) sidx <= '0;
    else if (tick) sidx <= sidx + 2'd1;
  // one-entry input buffer; committed into the store only at frame boundaries so a frame never tears
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d    <= {NUM_DIGITS{SEG_BLANK}};
      hold <= SEG_BLANK;
      pend <= 1'b0;
    end else if (clear) begin
      d    <= {NUM_DIGITS{SEG_BLANK}};
      pend <= 1'b0;
    end else if (frame && pend) begin
      d    <= {d[NUM_DIGITS-2:0], hold};
      pend <= 1'b0;
    end else if (seg_valid && seg_ready) begin
      hold <= seg_in;
      pend <= 1'b1;
    end
  // registered pin drive, blanked while disabled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= en ? ~(NUM_DIGITS'(1) << sidx) : '1;
      seg <= en ? d[sidx] : SEG_BLANK;
    end
endmodule
